// File: rtl/counter_pkg.sv
// Shared definitions for the periodic tick counter.
//
// COUNTER_WORDSIZE_DEFAULT : default width of the load value, count and
//                            reload registers.
// counter_next_count()     : the value the count register takes on an
//                            enabled cycle without a load (count down,
//                            reload from the reload register when at zero).
package counter_pkg;

    localparam int unsigned COUNTER_WORDSIZE_DEFAULT = 8;

    // The zero case reloads rather than wrapping, so the count never underflows.
    function automatic logic [63:0] counter_next_count(
        input logic [63:0] count,
        input logic [63:0] reload,
        input logic        is_zero
    );
        logic [63:0] next_count;
        next_count = is_zero ? reload : (count - 64'd1);
        return next_count;
    endfunction

endpackage

// File: rtl/counter.sv
// Loadable, auto-reloading down-counter used as a periodic tick generator.
//
// A load strobe captures the period value N into both the count and the
// reload register. While enabled, the count decrements once per cycle. When
// an enabled cycle finds the count at zero, the count reloads from the reload
// register and oReady pulses for one cycle. With N held and the enable high,
// this gives one tick every N+1 cycles.
//
// Priority on each rising edge: load > enable > hold.
//
// Ports
//   iClk      in   1         system clock, rising edge
//   iReset    in   1         asynchronous reset, active low
//   iLoad     in   1         load strobe for iCounter (count and reload)
//   iEnable   in   1         count enable
//   iCounter  in   WORDSIZE  period value N
//   oCounter  out  WORDSIZE  current count (register output)
//   oReady    out  1         terminal-count pulse (register output)
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WORDSIZE = COUNTER_WORDSIZE_DEFAULT
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iLoad,
    input  logic                iEnable,
    input  logic [WORDSIZE-1:0] iCounter,
    output logic [WORDSIZE-1:0] oCounter,
    output logic                oReady
);

    logic [WORDSIZE-1:0] r_count;
    logic [WORDSIZE-1:0] r_reload;
    logic                r_ready;

    logic                w_is_zero;
    logic [63:0]         w_next_wide;
    logic [WORDSIZE-1:0] w_next_count;

    assign w_is_zero    = (r_count == '0);
    assign w_next_wide  = counter_next_count(64'(r_count), 64'(r_reload), w_is_zero);
    assign w_next_count = w_next_wide[WORDSIZE-1:0];

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_count  <= '0;
            r_reload <= '0;
            r_ready  <= 1'b0;
        end else if (iLoad) begin
            // A load aborts any pending tick, including one due on this edge.
            r_count  <= iCounter;
            r_reload <= iCounter;
            r_ready  <= 1'b0;
        end else if (iEnable) begin
            r_count  <= w_next_count;
            r_ready  <= w_is_zero;
        end else begin
            // Count holds; the tick is never stretched across idle cycles.
            r_ready  <= 1'b0;
        end
    end

    assign oCounter = r_count;
    assign oReady   = r_ready;

endmodule

// File: tb/tb_counter.sv
// Randomized scoreboard bench for the periodic tick counter.
module tb_counter;

    logic       iClk;
    logic       iReset;
    logic       iLoad;
    logic       iEnable;
    logic [7:0] iCounter;
    logic [7:0] oCounter;
    logic       oReady;

    counter #(.WORDSIZE(8)) dut (
        .iClk     (iClk),
        .iReset   (iReset),
        .iLoad    (iLoad),
        .iEnable  (iEnable),
        .iCounter (iCounter),
        .oCounter (oCounter),
        .oReady   (oReady)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cyc    = 0;

    // Expected {oReady, oCounter} after each rising edge.
    logic [8:0] sb_q[$];

    // Reference model: period N and phase k = enabled edges since the last
    // load, taken modulo N+1. The count is N-k; a tick occurs on each enabled
    // edge that brings the phase back to 0.
    int m_n   = 0;
    int m_k   = 0;
    bit m_rdy = 0;

    function automatic void model_edge(input logic ld, input logic en, input logic [7:0] val);
        if (!iReset) begin
            m_n = 0; m_k = 0; m_rdy = 0;
        end else if (ld) begin
            m_n = int'(val); m_k = 0; m_rdy = 0;
        end else if (en) begin
            m_k   = (m_k + 1) % (m_n + 1);
            m_rdy = (m_k == 0);
        end else begin
            m_rdy = 0;
        end
    endfunction

    function automatic logic [8:0] model_out();
        logic [7:0] c;
        c = 8'(m_n - m_k);
        return {logic'(m_rdy), c};
    endfunction

    always @(negedge iClk) begin
        logic [8:0] exp;
        cyc++;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            checks++;
            if (oCounter !== exp[7:0] || oReady !== exp[8]) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got cnt=%0d rdy=%b expected cnt=%0d rdy=%b",
                         cyc, oCounter, oReady, exp[7:0], exp[8]);
            end
            if (oReady === 1'b1) pulses++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic ld, input logic en, input logic [7:0] val);
        iLoad = ld; iEnable = en; iCounter = val;
        @(posedge iClk);
        model_edge(ld, en, val);
        sb_q.push_back(model_out());
        #1;
    endtask

    // Assert reset between edges, after the scoreboard has consumed the last edge.
    task automatic async_reset(input int hold_cycles);
        @(negedge iClk);
        #2;
        iReset = 1'b0;
        #1;
        check("reset_async_cnt", int'(oCounter), 0);
        check("reset_async_rdy", int'(oReady), 0);
        m_n = 0; m_k = 0; m_rdy = 0;
        for (int i = 0; i < hold_cycles; i++) step(1'b1, 1'b1, 8'hA5);
        @(negedge iClk);
        #2;
        iReset = 1'b1;
    endtask

    int p0;

    initial begin
        iReset = 1'b0; iLoad = 1'b0; iEnable = 1'b0; iCounter = 8'h00;
        #12;
        check("reset_init_cnt", int'(oCounter), 0);
        check("reset_init_rdy", int'(oReady), 0);
        iReset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

        // Load 5 with enable low, then hold for 10 cycles.
        step(1'b1, 1'b0, 8'h05);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h33);

        // Count 4,3,2,1,0,5,...: 18 enabled cycles give exactly 3 ticks.
        @(negedge iClk); #1; p0 = pulses;
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 8'(i));
        @(negedge iClk); #1;
        check("period6_pulses", pulses - p0, 3);

        // Period zero: a tick every cycle.
        step(1'b1, 1'b0, 8'h00);
        @(negedge iClk); #1; p0 = pulses;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h77);
        @(negedge iClk); #1;
        check("period0_pulses", pulses - p0, 6);

        // Load and enable on the same edge, then one decrement.
        step(1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h00);
        @(negedge iClk); #1;
        check("load_ff_dec", int'(oCounter), 254);

        // Freeze at 2 for 3 cycles, then resume to the single tick.
        step(1'b1, 1'b0, 8'h05);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        @(negedge iClk); #1; p0 = pulses;
        check("freeze_at2", int'(oCounter), 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        @(negedge iClk); #1;
        check("freeze_pulses", pulses - p0, 1);
        check("freeze_reload", int'(oCounter), 5);

        // Load exactly on the zero cycle aborts the tick.
        step(1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h03);

        // Mid-operation async reset, then idle after release: no tick.
        step(1'b0, 1'b1, 8'h00);
        async_reset(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'hFF);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic ld, en;
            logic [7:0] v;
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
            step(ld, en, v);
            if ($urandom_range(0, 99) == 0) async_reset(int'($urandom_range(1, 3)));
        end

        iLoad = 1'b0; iEnable = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge iClk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
